// File: rtl/data_memory_wishbone_responder_pkg.sv
// Shared types for the data-memory Wishbone responder: bus word/select types
// and the latched request record.
package data_memory_wishbone_responder_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_wb_sel;

    localparam lc3b_wb_sel WB_SEL_LOW  = 2'b01;
    localparam lc3b_wb_sel WB_SEL_HIGH = 2'b10;
    localparam lc3b_wb_sel WB_SEL_WORD = 2'b11;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       we;
        lc3b_wb_sel sel;
        lc3b_word   dat;
    } wb_req_t;

endpackage

// File: rtl/data_memory_wishbone_responder_if.sv
// Wishbone data-memory bus between the MEM-stage controller and the responder.
interface data_memory_wishbone_responder_if;
    import data_memory_wishbone_responder_pkg::*;

    logic       CYC;
    logic       STB;
    logic       WE;
    lc3b_wb_sel SEL;
    lc3b_word   ADR;
    lc3b_word   DAT_M;
    lc3b_word   DAT_S;
    logic       ACK;
    logic       RTY;

    modport master (
        output CYC, STB, WE, SEL, ADR, DAT_M,
        input  DAT_S, ACK, RTY
    );

    modport slave (
        input  CYC, STB, WE, SEL, ADR, DAT_M,
        output DAT_S, ACK, RTY
    );

endinterface

// File: rtl/data_memory_wishbone_responder_wb_sram_array.sv
// Byte-writable 16-bit word array: one synchronous write port with per-byte
// enables and an asynchronous read port on the same word index.
module wb_sram_array
    import data_memory_wishbone_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 we,
    input  lc3b_wb_sel           be,
    input  lc3b_word             wdata,
    output lc3b_word             rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    // One bank per byte lane so each lane has a single writer.
    for (genvar b = 0; b < 2; b++) begin : g_lane
        logic [7:0] bank [DEPTH];

        always_ff @(posedge clk) begin
            if (we && be[b])
                bank[addr] <= wdata[b*8 +: 8];
        end

        assign rdata[b*8 +: 8] = bank[addr];
    end

endmodule

// File: rtl/data_memory_wishbone_responder.sv
// Wishbone responder for the data-memory port: fixed wait-state latency,
// one-cycle ACK, then a recovery window in which new requests get RTY.
module data_memory_wishbone_responder
    import data_memory_wishbone_responder_pkg::*;
#(
    parameter int ADDR_BITS       = 8,
    parameter int WAIT_CYCLES     = 2,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    data_memory_wishbone_responder_if.slave       wb
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_RECOVER
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] REC_CNT  = CNT_W'(RECOVERY_CYCLES);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 accept;
    wb_req_t              req;
    logic [ADDR_BITS-1:0] req_idx;
    lc3b_word             rd_data;
    lc3b_word             dat_hold;
    logic                 rd_ack;
    logic                 wr_commit;
    logic                 unused_adr;

    // ADR[0] and the bits above the array range are don't-care (address wraps).
    assign unused_adr = ^wb.ADR;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (wb.CYC && wb.STB) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_CNT;
                    end
                end
            end
            S_WAIT: begin
                if (!wb.CYC) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = S_ACK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            S_ACK: begin
                if (RECOVERY_CYCLES == 0) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_RECOVER;
                    cnt_nxt   = REC_CNT;
                end
            end
            S_RECOVER: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req      <= '0;
            req_idx  <= '0;
            dat_hold <= '0;
        end else begin
            if (accept) begin
                req.we  <= wb.WE;
                req.sel <= wb.SEL;
                req.dat <= wb.DAT_M;
                req_idx <= wb.ADR[ADDR_BITS:1];
            end
            if (rd_ack)
                dat_hold <= rd_data;
        end
    end

    assign rd_ack    = (state == S_ACK) && !req.we;
    assign wr_commit = (state == S_ACK) &&  req.we;

    wb_sram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .addr  (req_idx),
        .we    (wr_commit),
        .be    (req.sel),
        .wdata (req.dat),
        .rdata (rd_data)
    );

    // ACK and DAT_S depend only on registered state, never on bus inputs.
    assign wb.ACK   = (state == S_ACK);
    assign wb.RTY   = (state == S_RECOVER) && wb.CYC && wb.STB;
    assign wb.DAT_S = rd_ack ? rd_data : dat_hold;

endmodule
